// File: rtl/alu_flags.sv
// 64-bit ARMv8 datapath ALU: combinational result/zero/NZCV plus a
// write-enabled NZCV flag register for flag-setting instructions.
module alu_flags #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    input  logic         flag_we,
    output logic [N-1:0] result,
    output logic         zero,
    output logic [3:0]   nzcv,
    output logic [3:0]   flags_q
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASB = 4'b0111;
    localparam logic [3:0] OP_EOR  = 4'b1100;

    logic [N:0]   w_sumExt;
    logic [N:0]   w_diffExt;
    logic [N-1:0] w_result;
    logic         w_carry;
    logic         w_overflow;
    logic         w_zero;
    logic         w_neg;
    logic [3:0]   r_flags;

    // Extra top bit captures the carry out; subtraction is a + ~b + 1 so
    // its carry follows the ARM no-borrow convention (1 when a >= b).
    assign w_sumExt  = {1'b0, a} + {1'b0, b};
    assign w_diffExt = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};

    always_comb begin
        w_result   = a;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (ALUControl)
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_ADD: begin
                w_result   = w_sumExt[N-1:0];
                w_carry    = w_sumExt[N];
                w_overflow = (a[N-1] == b[N-1]) && (w_sumExt[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_result   = w_diffExt[N-1:0];
                w_carry    = w_diffExt[N];
                w_overflow = (a[N-1] != b[N-1]) && (w_diffExt[N-1] != a[N-1]);
            end
            OP_PASB: w_result = b;
            OP_EOR:  w_result = a ^ b;
            default: w_result = a;
        endcase
    end

    assign w_zero = (w_result == '0);
    assign w_neg  = w_result[N-1];

    assign result = w_result;
    assign zero   = w_zero;
    assign nzcv   = {w_neg, w_zero, w_carry, w_overflow};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= 4'b0000;
        end else if (flag_we) begin
            r_flags <= {w_neg, w_zero, w_carry, w_overflow};
        end
    end

    assign flags_q = r_flags;

endmodule

// File: tb/tb_alu_flags.sv
// Self-checking bench for alu_flags: scoreboard of expected result/zero/NZCV
// per vector, plus flag register load/hold/asynchronous reset scenarios.
module tb_alu_flags;

    logic        clk;
    logic        reset_n;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ALUControl;
    logic        flag_we;
    logic [63:0] result;
    logic        zero;
    logic [3:0]  nzcv;
    logic [3:0]  flags_q;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic [3:0]  f;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    alu_flags #(.N(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a          (a),
        .b          (b),
        .ALUControl (ALUControl),
        .flag_we    (flag_we),
        .result     (result),
        .zero       (zero),
        .nzcv       (nzcv),
        .flags_q    (flags_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [63:0] ALT_A = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] ALT_5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Drives one operation at a falling edge and records what it must produce.
    task automatic applyStimulus(input logic [3:0] ctl, input logic [63:0] av,
                                 input logic [63:0] bv, input logic [63:0] er,
                                 input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        ALUControl = ctl;
        a = av;
        b = bv;
        e.res = er;
        e.z   = ef[2];
        e.f   = ef;
        expQ.push_back(e);
        #1;
    endtask

    task automatic test_vectors(input string tag, input logic [3:0] ctl,
                                input logic [63:0] av, input logic [63:0] bv,
                                input logic [63:0] er, input logic [3:0] ef);
        exp_t e;
        applyStimulus(ctl, av, bv, er, ef);
        e = expQ.pop_front();
        nChecks++;
        if (result !== e.res) begin
            nFail++;
            $display("[TB] FAIL %s result: got %h expected %h", tag, result, e.res);
        end
        nChecks++;
        if (zero !== e.z) begin
            nFail++;
            $display("[TB] FAIL %s zero: got %b expected %b", tag, zero, e.z);
        end
        nChecks++;
        if (nzcv !== e.f) begin
            nFail++;
            $display("[TB] FAIL %s nzcv: got %b expected %b", tag, nzcv, e.f);
        end
    endtask

    task automatic test_reset;
        flag_we = 1'b0;
        ALUControl = 4'b0000;
        a = '0;
        b = '0;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (flags_q !== 4'b0000) begin
            nFail++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", flags_q);
        end
    endtask

    task automatic test_logic;
        test_vectors("and_mask", 4'b0000, ALT_A, 64'h0000_0000_FFFF_FFFF,
                     64'h0000_0000_AAAA_AAAA, 4'b0000);
        test_vectors("and_zero", 4'b0000, 64'h0, 64'h0000_0000_FFFF_FFFF, 64'h0, 4'b0100);
        test_vectors("or_alt",   4'b0001, ALT_A, ALT_5, ONES, 4'b1000);
        test_vectors("eor_alt",  4'b1100, ALT_A, ALT_5, ONES, 4'b1000);
        test_vectors("eor_same", 4'b1100, ALT_A, ALT_A, 64'h0, 4'b0100);
    endtask

    task automatic test_add;
        test_vectors("add_basic", 4'b0010, 64'h0123_4567, 64'h89AB_CDEF,
                     64'h8ACF_1356, 4'b0000);
        test_vectors("add_neg",   4'b0010, 64'hFFFF_FFFF_FFFF_FFE7, 64'h4,
                     64'hFFFF_FFFF_FFFF_FFEB, 4'b1000);
        test_vectors("add_carry", 4'b0010, ONES, 64'hA, 64'h9, 4'b0010);
        test_vectors("add_ovf",   4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                     64'h8000_0000_0000_0000, 4'b1001);
        test_vectors("add_cvz",   4'b0010, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0000, 64'h0, 4'b0111);
    endtask

    task automatic test_sub;
        test_vectors("sub_alt",  4'b0110, ONES, ALT_A, ALT_5, 4'b0010);
        test_vectors("sub_eq",   4'b0110, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hCCCC_CCCC_CCCC_CCCC, 64'h0, 4'b0110);
        test_vectors("sub_borrow", 4'b0110, 64'h0123_4567, 64'h89AB_CDEF,
                     64'hFFFF_FFFF_7777_7778, 4'b1000);
        test_vectors("sub_ovf",  4'b0110, 64'h8000_0000_0000_0000, 64'h1,
                     64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    endtask

    task automatic test_pass_default;
        test_vectors("passb",      4'b0111, ONES, ALT_A, ALT_A, 4'b1000);
        test_vectors("passb_zero", 4'b0111, ONES, 64'h0, 64'h0, 4'b0100);
        test_vectors("dflt",       4'b1010, ALT_A, ONES, ALT_A, 4'b1000);
        test_vectors("dflt_zero",  4'b1010, 64'h0, ONES, 64'h0, 4'b0100);
        test_vectors("dflt_x",     4'bxxxx, 64'h1234, ONES, 64'h1234, 4'b0000);
    endtask

    task automatic test_flags;
        // Release reset away from the clock edge, then load SUB a==b flags.
        @(negedge clk);
        reset_n = 1'b1;
        flag_we = 1'b1;
        ALUControl = 4'b0110;
        a = 64'hCCCC_CCCC_CCCC_CCCC;
        b = 64'hCCCC_CCCC_CCCC_CCCC;
        @(posedge clk);
        #1;
        nChecks++;
        if (flags_q !== 4'b0110) begin
            nFail++;
            $display("[TB] FAIL flags_load: got %b expected 0110", flags_q);
        end
        @(negedge clk);
        flag_we = 1'b0;
        ALUControl = 4'b0010;
        a = 64'h7FFF_FFFF_FFFF_FFFF;
        b = 64'h1;
        @(posedge clk);
        #1;
        nChecks++;
        if (flags_q !== 4'b0110) begin
            nFail++;
            $display("[TB] FAIL flags_hold: got %b expected 0110", flags_q);
        end
        nChecks++;
        if (nzcv !== 4'b1001) begin
            nFail++;
            $display("[TB] FAIL flags_hold_nzcv: got %b expected 1001", nzcv);
        end
        @(negedge clk);
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if (flags_q !== 4'b1001) begin
            nFail++;
            $display("[TB] FAIL flags_reload: got %b expected 1001", flags_q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (flags_q !== 4'b0000) begin
            nFail++;
            $display("[TB] FAIL flags_async_clr: got %b expected 0000", flags_q);
        end
        nChecks++;
        if (result !== 64'h8000_0000_0000_0000 || nzcv !== 4'b1001) begin
            nFail++;
            $display("[TB] FAIL comb_in_reset: got %h/%b expected 8000000000000000/1001",
                     result, nzcv);
        end
        @(posedge clk);
        #1;
        nChecks++;
        if (flags_q !== 4'b0000) begin
            nFail++;
            $display("[TB] FAIL flags_reset_held: got %b expected 0000", flags_q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ALUControl = 4'b0111;
        b = 64'h0;
        @(posedge clk);
        #1;
        nChecks++;
        if (flags_q !== 4'b0100) begin
            nFail++;
            $display("[TB] FAIL flags_first_edge: got %b expected 0100", flags_q);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add();
        test_sub();
        test_pass_default();
        test_flags();
        nChecks++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
